// File: rtl/swi_debouncer.sv
// rtl/swi_debouncer.sv - switch synchronizer and per-bit debouncer with rise/fall/toggle events
// A new level is accepted once it has held DEBOUNCE_CYCLES synchronized cycles.
module swi_debouncer #(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_clean,
    output logic [NBITS-1:0] swi_rise,
    output logic [NBITS-1:0] swi_fall,
    output logic [NBITS-1:0] swi_toggle,
    output logic             changed
);

    localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0]     r_sync1;
    logic [NBITS-1:0]     r_sync2;
    logic [NBITS-1:0]     r_clean;
    logic [NBITS-1:0]     r_rise;
    logic [NBITS-1:0]     r_fall;
    logic [NBITS-1:0]     r_toggle;
    logic                 r_changed;
    logic [CNT_WIDTH-1:0] r_cnt [NBITS];

    logic [NBITS-1:0]     w_mismatch;
    logic [NBITS-1:0]     w_accept;

    // A bit is accepted on the edge where its mismatch has already been counted DEBOUNCE_CYCLES-1 times.
    always_comb begin
        w_mismatch = r_sync2 ^ r_clean;
        w_accept   = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_accept[i] = w_mismatch[i] && (r_cnt[i] == LP_CNT_LAST);
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= swi_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NBITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if (!w_mismatch[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_clean   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_toggle  <= '0;
            r_changed <= 1'b0;
        end else begin
            r_clean   <= r_clean ^ w_accept;
            r_rise    <= w_accept & r_sync2;
            r_fall    <= w_accept & ~r_sync2;
            r_toggle  <= r_toggle ^ (w_accept & r_sync2);
            r_changed <= |w_accept;
        end
    end

    assign swi_clean  = r_clean;
    assign swi_rise   = r_rise;
    assign swi_fall   = r_fall;
    assign swi_toggle = r_toggle;
    assign changed    = r_changed;

endmodule

// File: tb/tb_swi_debouncer.sv
// tb/tb_swi_debouncer.sv - directed scoreboard bench for swi_debouncer (NBITS=8, DEBOUNCE_CYCLES=4)
module tb_swi_debouncer;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] swi_raw = 8'h00;
    logic [7:0] swi_clean;
    logic [7:0] swi_rise;
    logic [7:0] swi_fall;
    logic [7:0] swi_toggle;
    logic       changed;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] tog;
        logic       ch;
    } exp_t;

    exp_t sb[$];

    swi_debouncer #(
        .NBITS           (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .swi_raw    (swi_raw),
        .swi_clean  (swi_clean),
        .swi_rise   (swi_rise),
        .swi_fall   (swi_fall),
        .swi_toggle (swi_toggle),
        .changed    (changed)
    );

    always #5 clk_2 = ~clk_2;

    task automatic sb_push(input int n, input string tag, input logic [7:0] clean,
                           input logic [7:0] rise, input logic [7:0] fall,
                           input logic [7:0] tog, input logic ch);
        exp_t e;
        e.cyc   = cyc + n;
        e.tag   = tag;
        e.clean = clean;
        e.rise  = rise;
        e.fall  = fall;
        e.tog   = tog;
        e.ch    = ch;
        sb.push_back(e);
    endtask

    task automatic quiet(input int from, input int to, input string tag,
                         input logic [7:0] clean, input logic [7:0] tog);
        for (int n = from; n <= to; n++) begin
            sb_push(n, tag, clean, 8'h00, 8'h00, tog, 1'b0);
        end
    endtask

    task automatic cmp(input string tag, input string fld, input int at,
                       input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s.%s cycle=%0d observed=%h expected=%h", tag, fld, at, obs, exp_v);
        end
    endtask

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            cmp(e.tag, "clean",   e.cyc, swi_clean,        e.clean);
            cmp(e.tag, "rise",    e.cyc, swi_rise,         e.rise);
            cmp(e.tag, "fall",    e.cyc, swi_fall,         e.fall);
            cmp(e.tag, "toggle",  e.cyc, swi_toggle,       e.tog);
            cmp(e.tag, "changed", e.cyc, {7'b0, changed},  {7'b0, e.ch});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_2);
            cyc++;
            #1;
            check_due();
        end
    endtask

    // Asserts reset between edges, checks the asynchronous clear, holds two edges, then releases.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        sb_push(0, "rst_async", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        check_due();
        quiet(1, 2, "rst_hold", 8'h00, 8'h00);
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;

        // Raw held high through reset: rise on all bits six edges after release.
        swi_raw = 8'hFF;
        apply_reset();
        quiet(1, 5, "rst_high", 8'h00, 8'h00);
        sb_push(6, "rst_high", 8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);
        quiet(7, 7, "rst_high", 8'hFF, 8'hFF);
        run(7);

        swi_raw = 8'h00;
        quiet(1, 5, "all_fall", 8'hFF, 8'hFF);
        sb_push(6, "all_fall", 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1);
        quiet(7, 7, "all_fall", 8'h00, 8'hFF);
        run(7);

        swi_raw = 8'h08;
        quiet(1, 5, "bit3_rise", 8'h00, 8'hFF);
        sb_push(6, "bit3_rise", 8'h08, 8'h08, 8'h00, 8'hF7, 1'b1);
        quiet(7, 7, "bit3_rise", 8'h08, 8'hF7);
        run(7);

        // Three-cycle glitch on bit 0 is one cycle short of acceptance.
        swi_raw = 8'h09;
        quiet(1, 20, "glitch", 8'h08, 8'hF7);
        run(3);
        swi_raw = 8'h08;
        run(17);

        pat = 7'b1111011;
        quiet(1, 8, "bounce", 8'h08, 8'hF7);
        sb_push(9, "bounce", 8'h28, 8'h20, 8'h00, 8'hD7, 1'b1);
        quiet(10, 10, "bounce", 8'h28, 8'hD7);
        for (int i = 0; i < 7; i++) begin
            swi_raw[5] = pat[i];
            run(1);
        end
        run(3);

        swi_raw = 8'h00;
        apply_reset();
        swi_raw = 8'h42;
        quiet(1, 5, "pair", 8'h00, 8'h00);
        sb_push(6, "pair", 8'h42, 8'h42, 8'h00, 8'h42, 1'b1);
        quiet(7, 7, "pair", 8'h42, 8'h42);
        run(7);

        swi_raw = 8'h40;
        quiet(1, 5, "fall1", 8'h42, 8'h42);
        sb_push(6, "fall1", 8'h40, 8'h00, 8'h02, 8'h42, 1'b1);
        quiet(7, 7, "fall1", 8'h40, 8'h42);
        run(7);

        // Reset two counts into a bit-2 rise; raw stays high and is re-debounced from scratch.
        swi_raw = 8'h44;
        quiet(1, 4, "midcnt", 8'h40, 8'h42);
        run(4);
        apply_reset();
        quiet(1, 5, "rerun", 8'h00, 8'h00);
        sb_push(6, "rerun", 8'h44, 8'h44, 8'h00, 8'h44, 1'b1);
        quiet(7, 7, "rerun", 8'h44, 8'h44);
        run(7);

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/swi_debouncer.md
Name: swi_debouncer

Overview:
Input conditioning stage directly upstream of the board top level. Takes raw, asynchronous, bouncy switch levels and produces synchronized, debounced levels that drive the top's SWI bus. Also produces per-bit one-cycle rise/fall pulses, a per-bit toggle state and an any-change flag, so downstream logic can act on switch events instead of levels.

Parameters:
NBITS, 8, number of switch bits; matches the top-level switch/LED width.
DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a new level must hold before it is accepted; legal range >= 1.
CNT_WIDTH, $clog2(DEBOUNCE_CYCLES)+1, counter width; derived, never overridden.

Ports:
clk_2  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
swi_raw  input  NBITS  raw switch levels, asynchronous to clk_2.
swi_clean  output  NBITS  debounced level per bit; feeds top SWI.
swi_rise  output  NBITS  one-cycle pulse per bit when swi_clean[i] goes 0->1.
swi_fall  output  NBITS  one-cycle pulse per bit when swi_clean[i] goes 1->0.
swi_toggle  output  NBITS  per-bit state that inverts on every swi_rise[i].
changed  output  1  registered OR of (swi_rise | swi_fall), same cycle as the pulses.

Behaviour:
- Reset: asynchronous assert, and all registers clear immediately. This covers sync1, sync2, all counters, swi_clean, swi_rise, swi_fall, swi_toggle and changed, all = 0.
- Reset deasserts synchronously to clk_2 as seen by the logic. Reset mid-debounce discards all partial counts.
- Synchronizer: two flops per bit, sync1 <= swi_raw, then sync2 <= sync1. Only sync2 is used downstream.
- Per-bit counter cnt[i], every edge:
  - sync2[i] == swi_clean[i]: cnt[i] <= 0, no event.
  - sync2[i] != swi_clean[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != swi_clean[i] and cnt[i] == DEBOUNCE_CYCLES-1: swi_clean[i] <= sync2[i], cnt[i] <= 0, and the matching rise/fall bit is 1 for this cycle.
- Latency: raw level stable from before edge k (captured by sync1 at k) gives swi_clean updating at edge k+1+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=1 the latency is 2 edges.
- Glitch rejection: any sync2 excursion shorter than DEBOUNCE_CYCLES cycles returns the counter to 0 and produces no change and no pulse.
- Bounce restarts the count: a mismatch, then a match, then a mismatch starts counting from 0 again.
- Pulses:
  - swi_rise and swi_fall are registered and high for exactly one cycle, coincident with the swi_clean update.
  - Otherwise they are 0.
  - swi_rise[i] and swi_fall[i] are never both 1.
- Toggle: swi_toggle[i] inverts on the same edge that sets swi_rise[i]. Fall events do not affect it.
- changed: 1 in exactly the cycles where any rise or fall bit is 1.
- Bits are fully independent. Simultaneous events on several bits set several pulse bits in the same cycle, with a single changed pulse.
- Raw held high through reset: swi_clean is 0 after reset, so a rise pulse and a toggle occur DEBOUNCE_CYCLES+2 edges after reset release. This is required behaviour, not an error.
- Counter saturation is impossible: the counter resets on acceptance. There is no wrap-around.

Test Plan (DEBOUNCE_CYCLES=4, NBITS=8):
1. Assert reset with swi_raw=8'hFF, then release at edge 0 -> all outputs 0 through edge 5; swi_clean=8'hFF, swi_rise=8'hFF, changed=1 after edge 6 only; swi_toggle=8'hFF; pulses 0 after edge 7.
2. From clean 8'h00, set swi_raw[3]=1 before edge k and hold -> swi_clean=8'h08, swi_rise=8'h08 exactly after edge k+5; swi_fall=0 throughout.
3. swi_raw[0] high for 3 cycles then low, from clean 0 -> swi_clean, swi_rise and changed stay 0 for 20 cycles.
4. Bounce on bit 5: 1,1,0,1,1,1,1 per cycle, then held -> one rise only, 5 edges after the last 0->1 raw transition is captured; no earlier pulse.
5. Raw bits 1 and 6 go high in the same cycle -> one cycle with swi_rise=8'h42 and a single-cycle changed; then lowering bit 1 -> swi_fall=8'h02 once, with swi_toggle=8'h42 unchanged by the fall.
6. Assert reset mid-count (2 cycles into a bit-2 rise) -> outputs 0 immediately and asynchronously; after release the raw high is re-debounced, with the rise arriving 6 edges after release.
